video_rect_filler: RTL and testbench

VIDEO_RECT_FILLER -- requirements
Module: video_rect_filler

---
 rtl/video_rect_filler_pkg.sv | 25 ++
 rtl/video_byte_mask.sv | 20 ++
 rtl/video_rect_filler.sv | 196 +++++++++++++++++++
 tb/tb_video_rect_filler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_rect_filler_pkg.sv
// Shared definitions for the rectangle filler: frame bases, FSM encoding and
// the bus word payload.
package video_rect_filler_pkg;

    localparam logic [31:0] FRAME0_BASE = 32'hFF00_0000;
    localparam logic [31:0] FRAME1_BASE = 32'hFF10_0000;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned EXT_W   = COORD_W + 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        WRITE    = 3'd2,
        NEXT_ROW = 3'd3,
        DONE     = 3'd4
    } fill_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } bus_word_t;

endpackage

// File: rtl/video_byte_mask.sv
// Byte-lane enable for one 32-bit word: lane i is on when byte col_aligned+i
// falls inside [x_start, x_end].
module video_byte_mask
    import video_rect_filler_pkg::*;
(
    input  logic [COORD_W-1:0] col_aligned,
    input  logic [COORD_W-1:0] x_start,
    input  logic [COORD_W-1:0] x_end,
    output logic [3:0]         byte_mask_c
);

    always_comb begin
        byte_mask_c = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            byte_mask_c[i] = (({1'b0, col_aligned} + EXT_W'(i)) >= {1'b0, x_start}) &&
                             (({1'b0, col_aligned} + EXT_W'(i)) <= {1'b0, x_end});
        end
    end

endmodule

// File: rtl/video_rect_filler.sv
// Fills a clipped rectangle of 8-bit pixels in one of two framebuffers using
// word-wide byte-masked bus writes.
module video_rect_filler
    import video_rect_filler_pkg::*;
#(
    parameter int unsigned FB_WIDTH  = 320,
    parameter int unsigned FB_HEIGHT = 240
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [9:0]  rect_x,
    input  logic [9:0]  rect_y,
    input  logic [9:0]  rect_width,
    input  logic [9:0]  rect_height,
    input  logic [7:0]  fill_color,
    input  logic        frame_select,
    input  logic        bus_grant,
    output logic [31:0] bus_address,
    output logic [31:0] bus_write_data,
    output logic [3:0]  bus_byte_enable,
    output logic        bus_write_enable,
    output logic        bus_read_enable,
    output logic        busy,
    output logic        done
);

    localparam logic [EXT_W-1:0] FB_W_EXT = EXT_W'(FB_WIDTH);
    localparam logic [EXT_W-1:0] FB_H_EXT = EXT_W'(FB_HEIGHT);

    fill_state_e          state_q, state_d;
    logic [COORD_W-1:0]   x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
    logic [COORD_W-1:0]   col_q, col_d, row_q, row_d;
    logic [7:0]           color_q, color_d;
    logic                 frame_q, frame_d;
    logic                 we_q, we_d, busy_q, busy_d, done_q, done_d;
    bus_word_t            bus_q, bus_d;
    logic                 load_c;

    logic [EXT_W-1:0]     x_sum_c, y_sum_c, x_lim_c, y_lim_c;
    logic [COORD_W-1:0]   x_end_c, y_end_c;
    logic                 empty_c;
    logic [3:0]           mask_c;

    // Clipped inclusive end coordinates; 11-bit sums cannot wrap.
    always_comb begin
        x_sum_c = {1'b0, x_q} + {1'b0, w_q};
        y_sum_c = {1'b0, y_q} + {1'b0, h_q};
        x_lim_c = (x_sum_c > FB_W_EXT) ? FB_W_EXT : x_sum_c;
        y_lim_c = (y_sum_c > FB_H_EXT) ? FB_H_EXT : y_sum_c;
        x_end_c = COORD_W'(x_lim_c - EXT_W'(1));
        y_end_c = COORD_W'(y_lim_c - EXT_W'(1));
        empty_c = (w_q == '0) || (h_q == '0) ||
                  ({1'b0, x_q} >= FB_W_EXT) || ({1'b0, y_q} >= FB_H_EXT);
    end

    // Next-state and walk of the (row, col) cursor.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        h_d     = h_q;
        color_d = color_q;
        frame_d = frame_q;
        col_d   = col_q;
        row_d   = row_q;
        we_d    = we_q;
        load_c  = 1'b0;

        case (state_q)
            IDLE: begin
                we_d = 1'b0;
                if (start && !abort) begin
                    x_d     = rect_x;
                    y_d     = rect_y;
                    w_d     = rect_width;
                    h_d     = rect_height;
                    color_d = fill_color;
                    frame_d = frame_select;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (empty_c) begin
                    state_d = DONE;
                end else begin
                    col_d   = x_q;
                    row_d   = y_q;
                    we_d    = 1'b1;
                    load_c  = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (we_q && bus_grant) begin
                    if ({col_q[COORD_W-1:2], 2'b11} >= x_end_c) begin
                        we_d    = 1'b0;
                        state_d = NEXT_ROW;
                    end else begin
                        col_d  = {col_q[COORD_W-1:2] + 8'd1, 2'b00};
                        load_c = 1'b1;
                    end
                end
            end
            NEXT_ROW: begin
                if (row_q == y_end_c) begin
                    state_d = DONE;
                end else begin
                    row_d   = row_q + 10'd1;
                    col_d   = x_q;
                    we_d    = 1'b1;
                    load_c  = 1'b1;
                    state_d = WRITE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                we_d    = 1'b0;
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            we_d    = 1'b0;
            load_c  = 1'b0;
        end

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    video_byte_mask u_byte_mask (
        .col_aligned (({col_d[COORD_W-1:2], 2'b00})),
        .x_start     (x_q),
        .x_end       (x_end_c),
        .byte_mask_c (mask_c)
    );

    // Bus word is only reloaded when a new write is presented, so it holds while stalled.
    always_comb begin
        bus_d = bus_q;
        if (load_c) begin
            bus_d.addr = (frame_q ? FRAME1_BASE : FRAME0_BASE)
                       + 32'(row_d) * 32'(FB_WIDTH)
                       + 32'({col_d[COORD_W-1:2], 2'b00});
            bus_d.data = {4{color_q}};
            bus_d.be   = mask_c;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            color_q <= '0;
            frame_q <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bus_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            h_q     <= h_d;
            color_q <= color_d;
            frame_q <= frame_d;
            col_q   <= col_d;
            row_q   <= row_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bus_q   <= bus_d;
        end
    end

    assign bus_address      = bus_q.addr;
    assign bus_write_data   = bus_q.data;
    assign bus_byte_enable  = bus_q.be;
    assign bus_write_enable = we_q;
    assign bus_read_enable  = 1'b0;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_video_rect_filler.sv
// Scoreboard bench for video_rect_filler: directed fills push expected bus
// words, a negedge monitor pops and compares every accepted write.
module tb_video_rect_filler;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, abort = 1'b0;
    logic [9:0]  rect_x = '0, rect_y = '0, rect_width = '0, rect_height = '0;
    logic [7:0]  fill_color = '0;
    logic        frame_select = 1'b0;
    logic        bus_grant = 1'b1;
    logic [31:0] bus_address, bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_write_enable, bus_read_enable, busy, done;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   writes_seen = 0;
    int   done_count = 0;
    int   done_cyc = 0;
    int   last_wr_cyc = 0;
    int   first_wr_cyc = -1;
    int   start_cyc = 0;

    video_rect_filler #(.FB_WIDTH(320), .FB_HEIGHT(240)) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .rect_x           (rect_x),
        .rect_y           (rect_y),
        .rect_width       (rect_width),
        .rect_height      (rect_height),
        .fill_color       (fill_color),
        .frame_select     (frame_select),
        .bus_grant        (bus_grant),
        .bus_address      (bus_address),
        .bus_write_data   (bus_write_data),
        .bus_byte_enable  (bus_byte_enable),
        .bus_write_enable (bus_write_enable),
        .bus_read_enable  (bus_read_enable),
        .busy             (busy),
        .done             (done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [7:0] c, input logic [3:0] be);
        exp_t e;
        e.a  = a;
        e.d  = {4{c}};
        e.be = be;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted write must match the head of the scoreboard.
    always @(negedge clock) begin
        exp_t e, got;
        if (reset) begin
            if (bus_write_enable && bus_grant) begin
                got.a  = bus_address;
                got.d  = bus_write_data;
                got.be = bus_byte_enable;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 68'(got), 68'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("bus_write", 68'(got), 68'(e));
                end
                writes_seen++;
                last_wr_cyc = cyc;
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
        end
    end

    task automatic launch(input logic [9:0] x, input logic [9:0] y, input logic [9:0] w,
                          input logic [9:0] h, input logic [7:0] c, input logic f);
        @(posedge clock); #1;
        rect_x = x; rect_y = y; rect_width = w; rect_height = h;
        fill_color = c; frame_select = f; start = 1'b1;
        start_cyc = cyc;
        first_wr_cyc = -1;
        @(posedge clock); #1;
        start = 1'b0;
        // Scramble inputs; the captured copy must be used.
        rect_x = 10'h3FF; rect_width = 10'h001; fill_color = ~c; frame_select = ~f;
    endtask

    task automatic wait_done(input string name, output int dc);
        int d0 = done_count;
        int i = 0;
        while (done_count == d0 && i < 500) begin
            @(negedge clock); #1;
            i++;
        end
        if (done_count == d0) begin
            chk({name, "_done_timeout"}, 68'(0), 68'(1));
            dc = -1;
        end else begin
            dc = done_cyc;
            @(negedge clock); #1;
            chk({name, "_done_width"}, 68'(done), 68'(0));
            chk({name, "_idle_busy"}, 68'(busy), 68'(0));
        end
    endtask

    task automatic wait_writes(input string name, input int n);
        int i = 0;
        while (writes_seen < n && i < 200) begin
            @(negedge clock); #1;
            i++;
        end
        if (writes_seen < n) chk({name, "_write_timeout"}, 68'(writes_seen), 68'(n));
    endtask

    initial begin
        int dc, base, dn;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", 68'(busy), 68'(0));
        chk("rst_done", 68'(done), 68'(0));
        chk("rst_we", 68'(bus_write_enable), 68'(0));
        chk("rst_re", 68'(bus_read_enable), 68'(0));
        chk("rst_bus", 68'({bus_address, bus_write_data, bus_byte_enable}), 68'(0));
        @(posedge clock); #1;
        reset = 1'b1;

        // Two full rows, frame 0
        push(32'hFF00_0000, 8'hA5, 4'b1111);
        push(32'hFF00_0004, 8'hA5, 4'b1111);
        push(32'hFF00_0140, 8'hA5, 4'b1111);
        push(32'hFF00_0144, 8'hA5, 4'b1111);
        launch(10'd0, 10'd0, 10'd8, 10'd2, 8'hA5, 1'b0);
        chk("basic_busy", 68'(busy), 68'(1));
        wait_done("basic", dc);
        chk("basic_first_lat", 68'(first_wr_cyc - start_cyc), 68'(2));
        chk("basic_done_lat", 68'(dc - last_wr_cyc), 68'(2));
        chk("basic_q_empty", 68'(exp_q.size()), 68'(0));

        // Unaligned start, partial masks, frame 1
        push(32'hFF10_0000, 8'h3C, 4'b1110);
        push(32'hFF10_0004, 8'h3C, 4'b0111);
        launch(10'd1, 10'd0, 10'd6, 10'd1, 8'h3C, 1'b1);
        wait_done("partial", dc);
        chk("partial_q_empty", 68'(exp_q.size()), 68'(0));

        // Bottom-right corner clipped to a single word
        push(32'hFF01_2BFC, 8'h77, 4'b1100);
        launch(10'd318, 10'd239, 10'd10, 10'd10, 8'h77, 1'b0);
        wait_done("clip", dc);
        chk("clip_q_empty", 68'(exp_q.size()), 68'(0));

        // Zero width: no writes, done two cycles after start
        base = writes_seen;
        launch(10'd4, 10'd4, 10'd0, 10'd5, 8'h11, 1'b0);
        wait_done("zero_w", dc);
        chk("zero_w_done_lat", 68'(dc - start_cyc), 68'(2));
        chk("zero_w_no_write", 68'(writes_seen), 68'(base));

        // Origin past the right edge: no writes
        launch(10'd320, 10'd5, 10'd4, 10'd4, 8'h22, 1'b0);
        wait_done("off_x", dc);
        chk("off_x_done_lat", 68'(dc - start_cyc), 68'(2));
        chk("off_x_no_write", 68'(writes_seen), 68'(base));

        // Grant held low for 5 cycles on the second word
        base = writes_seen;
        push(32'hFF00_0000, 8'h5E, 4'b1111);
        push(32'hFF00_0004, 8'h5E, 4'b1111);
        push(32'hFF00_0008, 8'h5E, 4'b1111);
        launch(10'd0, 10'd0, 10'd12, 10'd1, 8'h5E, 1'b0);
        wait_writes("stall", base + 1);
        @(posedge clock); #1;
        bus_grant = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("stall_hold", 68'({bus_write_enable, bus_address, bus_write_data, bus_byte_enable}),
                68'({1'b1, 32'hFF00_0004, 32'h5E5E_5E5E, 4'b1111}));
            chk("stall_count", 68'(writes_seen), 68'(base + 1));
        end
        @(posedge clock); #1;
        bus_grant = 1'b1;
        wait_done("stall", dc);
        chk("stall_q_empty", 68'(exp_q.size()), 68'(0));

        // Abort during row 1
        base = writes_seen;
        dn = done_count;
        push(32'hFF00_0000, 8'hC3, 4'b1111);
        push(32'hFF00_0004, 8'hC3, 4'b1111);
        launch(10'd0, 10'd0, 10'd8, 10'd3, 8'hC3, 1'b0);
        wait_writes("abort", base + 2);
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("abort_row1_addr", 68'({bus_write_enable, bus_address}), 68'({1'b1, 32'hFF00_0140}));
        bus_grant = 1'b0;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        chk("abort_we", 68'(bus_write_enable), 68'(0));
        chk("abort_busy", 68'(busy), 68'(0));
        bus_grant = 1'b1;
        repeat (10) @(negedge clock);
        chk("abort_no_done", 68'(done_count), 68'(dn));
        chk("abort_q_empty", 68'(exp_q.size()), 68'(0));

        // Abort and start together in IDLE: start ignored
        base = writes_seen;
        @(posedge clock); #1;
        rect_x = 10'd0; rect_y = 10'd0; rect_width = 10'd4; rect_height = 10'd1;
        start = 1'b1; abort = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", 68'(busy), 68'(0));
        repeat (5) @(negedge clock);
        chk("abort_start_no_write", 68'(writes_seen), 68'(base));

        // Reset mid-fill
        dn = done_count;
        push(32'hFF00_0000, 8'h5A, 4'b1111);
        launch(10'd0, 10'd0, 10'd8, 10'd2, 8'h5A, 1'b0);
        base = writes_seen;
        wait_writes("rst_mid", base + 1);
        @(posedge clock); #1;
        bus_grant = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_we", 68'(bus_write_enable), 68'(0));
        chk("rst_mid_busy", 68'(busy), 68'(0));
        chk("rst_mid_bus", 68'({bus_address, bus_write_data, bus_byte_enable}), 68'(0));
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        bus_grant = 1'b1;
        repeat (10) @(negedge clock);
        chk("rst_mid_idle", 68'(busy), 68'(0));
        chk("rst_mid_no_done", 68'(done_count), 68'(dn));
        chk("rst_mid_q_empty", 68'(exp_q.size()), 68'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
